// File: rtl/intr_ctrl_if.sv
// Signal bundle between the MCU control unit and intr_ctrl.
// master drives requests, mask and handshakes; slave is the controller.
interface intr_ctrl_if #(
  parameter int N_SRC = 4
);
  localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] src_in;
  logic             mask_we;
  logic [N_SRC-1:0] mask_din;
  logic             sei;
  logic             cli;
  logic             int_ack;
  logic             retie;
  logic             flag_c_in;
  logic             flag_z_in;

  logic             int_req;
  logic [IDW-1:0]   int_id;
  logic [9:0]       int_vec;
  logic             int_en;
  logic             in_service;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] mask_q;
  logic             flag_c_shad;
  logic             flag_z_shad;

  modport master (
    output src_in, mask_we, mask_din, sei, cli, int_ack, retie, flag_c_in, flag_z_in,
    input  int_req, int_id, int_vec, int_en, in_service, pending_q, mask_q,
           flag_c_shad, flag_z_shad
  );

  modport slave (
    input  src_in, mask_we, mask_din, sei, cli, int_ack, retie, flag_c_in, flag_z_in,
    output int_req, int_id, int_vec, int_en, in_service, pending_q, mask_q,
           flag_c_shad, flag_z_shad
  );
endinterface

// File: rtl/intr_ctrl.sv
// Edge-latching interrupt controller: pending/mask/I-flag -> single request, ack -> ISR until RETIE.
// src_in rise to int_req is 2 cycles (4 with INTR_SYNC_EN input synchronizers); no nesting, requests wait out SERVICE.
module intr_ctrl #(
  parameter int         N_SRC    = 4,
  parameter logic [9:0] VEC_BASE = 10'h3F8
) (
  input  logic       clk,
  input  logic       reset,
  intr_ctrl_if.slave bus
);
  localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_n;

  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] src_prev;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] pending_n;
  logic [N_SRC-1:0] mask_r;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   id_r;
  logic [IDW-1:0]   id_out;
  logic             en_r;
  logic             en_n;
  logic             c_shad_r;
  logic             z_shad_r;
  logic             req;
  logic             svc;
  logic             ack_acc;
  logic             retie_acc;

`ifdef INTR_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.src_in;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = bus.src_in;
`endif

  assign rise     = src_s & ~src_prev;
  assign eligible = pending_r & mask_r;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win = IDW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    req       = 1'b0;
    svc       = 1'b0;
    ack_acc   = 1'b0;
    retie_acc = 1'b0;
    id_out    = id_r;
    unique case (state_q)
      IDLE: begin
        if (en_r && (|eligible)) state_n = REQ;
      end
      REQ: begin
        // Request drops the same cycle eligibility or I goes away, so an ack can never hit an empty winner.
        req = en_r && (|eligible);
        if (req) begin
          id_out = win;
          if (bus.int_ack) begin
            ack_acc = 1'b1;
            state_n = SERVICE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SERVICE: begin
        svc = 1'b1;
        if (bus.retie) begin
          retie_acc = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A fresh edge on the acknowledged source outranks the clear.
  assign clr       = ack_acc ? (N_SRC'(1) << win) : '0;
  assign pending_n = (pending_r & ~clr) | rise;

  always_comb begin
    en_n = en_r;
    if (bus.sei)  en_n = 1'b1;
    if (retie_acc) en_n = 1'b1;
    if (ack_acc)  en_n = 1'b0;
    if (bus.cli)  en_n = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_prev  <= '0;
      pending_r <= '0;
      mask_r    <= '1;
      en_r      <= 1'b0;
      c_shad_r  <= 1'b0;
      z_shad_r  <= 1'b0;
      id_r      <= '0;
    end else begin
      src_prev  <= src_s;
      pending_r <= pending_n;
      en_r      <= en_n;
      if (bus.mask_we) mask_r <= bus.mask_din;
      if (ack_acc) begin
        id_r     <= win;
        c_shad_r <= bus.flag_c_in;
        z_shad_r <= bus.flag_z_in;
      end
    end
  end

  assign bus.int_req     = req;
  assign bus.in_service  = svc;
  assign bus.int_id      = id_out;
  assign bus.int_vec     = VEC_BASE + 10'(id_out);
  assign bus.int_en      = en_r;
  assign bus.pending_q   = pending_r;
  assign bus.mask_q      = mask_r;
  assign bus.flag_c_shad = c_shad_r;
  assign bus.flag_z_shad = z_shad_r;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with N_SRC=4, VEC_BASE=10'h3F8.
module tb_intr_ctrl;
`ifdef INTR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic reset;
  int   pass_cnt;
  int   chk_cnt;

  intr_ctrl_if #(.N_SRC(4)) bus ();

  intr_ctrl #(.N_SRC(4), .VEC_BASE(10'h3F8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    bus.src_in = v;
    tick(1);
    bus.src_in = 4'b0000;
  endtask

  task automatic test_reset;
    chk_cnt++; if (bus.int_req !== 1'b0) $display("FAIL rst_req got=%0b exp=0", bus.int_req); else pass_cnt++;
    chk_cnt++; if (bus.in_service !== 1'b0) $display("FAIL rst_svc got=%0b exp=0", bus.in_service); else pass_cnt++;
    chk_cnt++; if (bus.int_vec !== 10'h3F8) $display("FAIL rst_vec got=%h exp=3f8", bus.int_vec); else pass_cnt++;
    chk_cnt++; if (bus.int_id !== 2'd0) $display("FAIL rst_id got=%0d exp=0", bus.int_id); else pass_cnt++;
    chk_cnt++; if (bus.int_en !== 1'b0) $display("FAIL rst_en got=%0b exp=0", bus.int_en); else pass_cnt++;
    chk_cnt++; if (bus.pending_q !== 4'b0000) $display("FAIL rst_pend got=%b exp=0000", bus.pending_q); else pass_cnt++;
    chk_cnt++; if (bus.mask_q !== 4'b1111) $display("FAIL rst_mask got=%b exp=1111", bus.mask_q); else pass_cnt++;
    chk_cnt++; if ({bus.flag_c_shad, bus.flag_z_shad} !== 2'b00) $display("FAIL rst_shad got=%b exp=00", {bus.flag_c_shad, bus.flag_z_shad}); else pass_cnt++;
  endtask

  task automatic test_basic;
    bus.sei = 1'b1; tick(1); bus.sei = 1'b0;
    pulse(4'b0100);
    for (int k = 2; k <= LAT; k++) begin
      chk_cnt++; if (bus.int_req !== 1'b0) $display("FAIL basic_early edge=%0d got=%0b exp=0", k - 1, bus.int_req); else pass_cnt++;
      tick(1);
    end
    chk_cnt++; if (bus.int_req !== 1'b1) $display("FAIL basic_req got=%0b exp=1", bus.int_req); else pass_cnt++;
    chk_cnt++; if (bus.int_id !== 2'd2) $display("FAIL basic_id got=%0d exp=2", bus.int_id); else pass_cnt++;
    chk_cnt++; if (bus.int_vec !== 10'h3FA) $display("FAIL basic_vec got=%h exp=3fa", bus.int_vec); else pass_cnt++;
  endtask

  task automatic test_ack_retie;
    bus.flag_c_in = 1'b1; bus.flag_z_in = 1'b0;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk_cnt++; if (bus.in_service !== 1'b1) $display("FAIL ack_svc got=%0b exp=1", bus.in_service); else pass_cnt++;
    chk_cnt++; if (bus.int_en !== 1'b0) $display("FAIL ack_en got=%0b exp=0", bus.int_en); else pass_cnt++;
    chk_cnt++; if (bus.pending_q !== 4'b0000) $display("FAIL ack_pend got=%b exp=0000", bus.pending_q); else pass_cnt++;
    chk_cnt++; if ({bus.flag_c_shad, bus.flag_z_shad} !== 2'b10) $display("FAIL ack_shad got=%b exp=10", {bus.flag_c_shad, bus.flag_z_shad}); else pass_cnt++;
    chk_cnt++; if (bus.int_req !== 1'b0) $display("FAIL ack_req got=%0b exp=0", bus.int_req); else pass_cnt++;
    chk_cnt++; if (bus.int_id !== 2'd2) $display("FAIL ack_id got=%0d exp=2", bus.int_id); else pass_cnt++;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
    chk_cnt++; if (bus.int_en !== 1'b1) $display("FAIL retie_en got=%0b exp=1", bus.int_en); else pass_cnt++;
    chk_cnt++; if (bus.in_service !== 1'b0) $display("FAIL retie_svc got=%0b exp=0", bus.in_service); else pass_cnt++;
    // retie outside SERVICE, then sei+cli together
    bus.cli = 1'b1; tick(1); bus.cli = 1'b0;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
    chk_cnt++; if (bus.int_en !== 1'b0) $display("FAIL stray_retie_en got=%0b exp=0", bus.int_en); else pass_cnt++;
    bus.sei = 1'b1; bus.cli = 1'b1; tick(1); bus.sei = 1'b0; bus.cli = 1'b0;
    chk_cnt++; if (bus.int_en !== 1'b0) $display("FAIL sei_cli_en got=%0b exp=0", bus.int_en); else pass_cnt++;
    bus.sei = 1'b1; tick(1); bus.sei = 1'b0;
    chk_cnt++; if (bus.int_en !== 1'b1) $display("FAIL sei_en got=%0b exp=1", bus.int_en); else pass_cnt++;
  endtask

  task automatic test_priority;
    pulse(4'b1010); tick(LAT - 1);
    chk_cnt++; if ({bus.int_req, bus.int_id} !== 3'b1_01) $display("FAIL prio_first got=%b exp=101", {bus.int_req, bus.int_id}); else pass_cnt++;
    chk_cnt++; if (bus.int_vec !== 10'h3F9) $display("FAIL prio_vec got=%h exp=3f9", bus.int_vec); else pass_cnt++;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk_cnt++; if (bus.pending_q !== 4'b1000) $display("FAIL prio_pend got=%b exp=1000", bus.pending_q); else pass_cnt++;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
    tick(1);
    chk_cnt++; if ({bus.int_req, bus.int_id} !== 3'b1_11) $display("FAIL prio_second got=%b exp=111", {bus.int_req, bus.int_id}); else pass_cnt++;
    chk_cnt++; if (bus.int_vec !== 10'h3FB) $display("FAIL prio_vec2 got=%h exp=3fb", bus.int_vec); else pass_cnt++;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
  endtask

  task automatic test_disabled;
    bus.cli = 1'b1; tick(1); bus.cli = 1'b0;
    pulse(4'b0001); tick(LAT);
    chk_cnt++; if (bus.pending_q !== 4'b0001) $display("FAIL dis_pend got=%b exp=0001", bus.pending_q); else pass_cnt++;
    chk_cnt++; if (bus.int_req !== 1'b0) $display("FAIL dis_req got=%0b exp=0", bus.int_req); else pass_cnt++;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk_cnt++; if ({bus.pending_q, bus.in_service} !== 5'b0001_0) $display("FAIL stray_ack got=%b exp=00010", {bus.pending_q, bus.in_service}); else pass_cnt++;
    bus.sei = 1'b1; tick(1); bus.sei = 1'b0;
    chk_cnt++; if (bus.int_req !== 1'b0) $display("FAIL sei_req_early got=%0b exp=0", bus.int_req); else pass_cnt++;
    tick(1);
    chk_cnt++; if ({bus.int_req, bus.int_id} !== 3'b1_00) $display("FAIL sei_req got=%b exp=100", {bus.int_req, bus.int_id}); else pass_cnt++;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
  endtask

  task automatic test_mask;
    bus.mask_we = 1'b1; bus.mask_din = 4'b1110; tick(1); bus.mask_we = 1'b0;
    chk_cnt++; if (bus.mask_q !== 4'b1110) $display("FAIL mask_q got=%b exp=1110", bus.mask_q); else pass_cnt++;
    pulse(4'b0001); tick(LAT);
    chk_cnt++; if ({bus.pending_q, bus.int_req} !== 5'b0001_0) $display("FAIL mask_block got=%b exp=00010", {bus.pending_q, bus.int_req}); else pass_cnt++;
    bus.mask_we = 1'b1; bus.mask_din = 4'b1111; tick(1); bus.mask_we = 1'b0;
    tick(1);
    chk_cnt++; if ({bus.int_req, bus.int_id} !== 3'b1_00) $display("FAIL unmask_req got=%b exp=100", {bus.int_req, bus.int_id}); else pass_cnt++;
    pulse(4'b0010); tick(LAT - 1);
    chk_cnt++; if (bus.pending_q !== 4'b0011) $display("FAIL mask_pend2 got=%b exp=0011", bus.pending_q); else pass_cnt++;
    // mask write racing the ack: ack must still take source 0
    bus.int_ack = 1'b1; bus.mask_we = 1'b1; bus.mask_din = 4'b1110; tick(1);
    bus.int_ack = 1'b0; bus.mask_we = 1'b0;
    chk_cnt++; if ({bus.in_service, bus.int_id} !== 3'b1_00) $display("FAIL mask_ack_id got=%b exp=100", {bus.in_service, bus.int_id}); else pass_cnt++;
    chk_cnt++; if ({bus.pending_q, bus.mask_q} !== 8'b0010_1110) $display("FAIL mask_ack_state got=%b exp=00101110", {bus.pending_q, bus.mask_q}); else pass_cnt++;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
    tick(1);
    chk_cnt++; if ({bus.int_req, bus.int_id} !== 3'b1_01) $display("FAIL mask_next got=%b exp=101", {bus.int_req, bus.int_id}); else pass_cnt++;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
    bus.mask_we = 1'b1; bus.mask_din = 4'b1111; tick(1); bus.mask_we = 1'b0;
    // level held high latches once
    bus.src_in = 4'b0010; tick(LAT);
    chk_cnt++; if ({bus.int_req, bus.int_id, bus.pending_q} !== 7'b1_01_0010) $display("FAIL hold_req got=%b exp=1010010", {bus.int_req, bus.int_id, bus.pending_q}); else pass_cnt++;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    tick(7);
    chk_cnt++; if (bus.pending_q !== 4'b0000) $display("FAIL hold_pend got=%b exp=0000", bus.pending_q); else pass_cnt++;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
    tick(2);
    chk_cnt++; if ({bus.int_req, bus.pending_q} !== 5'b0_0000) $display("FAIL hold_after got=%b exp=00000", {bus.int_req, bus.pending_q}); else pass_cnt++;
    bus.src_in = 4'b0000; tick(LAT);
  endtask

  task automatic test_set_wins;
    pulse(4'b0100); tick(LAT - 1);
    chk_cnt++; if ({bus.int_req, bus.int_id} !== 3'b1_10) $display("FAIL setwin_req got=%b exp=110", {bus.int_req, bus.int_id}); else pass_cnt++;
    bus.src_in = 4'b0100;
    tick(LAT - 2);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0; bus.src_in = 4'b0000;
    chk_cnt++; if ({bus.in_service, bus.pending_q} !== 5'b1_0100) $display("FAIL setwin_pend got=%b exp=10100", {bus.in_service, bus.pending_q}); else pass_cnt++;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
    tick(1);
    chk_cnt++; if ({bus.int_req, bus.int_id} !== 3'b1_10) $display("FAIL setwin_again got=%b exp=110", {bus.int_req, bus.int_id}); else pass_cnt++;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    bus.retie = 1'b1; tick(1); bus.retie = 1'b0;
    chk_cnt++; if (bus.pending_q !== 4'b0000) $display("FAIL setwin_clean got=%b exp=0000", bus.pending_q); else pass_cnt++;
  endtask

  task automatic test_service_reset;
    pulse(4'b0100); tick(LAT - 1);
    bus.flag_c_in = 1'b1; bus.flag_z_in = 1'b1;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk_cnt++; if ({bus.flag_c_shad, bus.flag_z_shad} !== 2'b11) $display("FAIL svc_shad got=%b exp=11", {bus.flag_c_shad, bus.flag_z_shad}); else pass_cnt++;
    pulse(4'b0001); tick(LAT);
    chk_cnt++; if ({bus.pending_q, bus.in_service, bus.int_req} !== 6'b0001_1_0) $display("FAIL svc_latch got=%b exp=000110", {bus.pending_q, bus.in_service, bus.int_req}); else pass_cnt++;
    bus.sei = 1'b1; tick(1); bus.sei = 1'b0;
    chk_cnt++; if ({bus.int_en, bus.in_service, bus.int_req} !== 3'b110) $display("FAIL svc_sei got=%b exp=110", {bus.int_en, bus.in_service, bus.int_req}); else pass_cnt++;
    #3 reset = 1'b1;
    #1;
    chk_cnt++; if ({bus.in_service, bus.int_req, bus.int_en} !== 3'b000) $display("FAIL arst_ctl got=%b exp=000", {bus.in_service, bus.int_req, bus.int_en}); else pass_cnt++;
    chk_cnt++; if ({bus.pending_q, bus.mask_q} !== 8'b0000_1111) $display("FAIL arst_regs got=%b exp=00001111", {bus.pending_q, bus.mask_q}); else pass_cnt++;
    chk_cnt++; if ({bus.int_vec, bus.int_id} !== {10'h3F8, 2'd0}) $display("FAIL arst_vec got=%h exp=fe0", {bus.int_vec, bus.int_id}); else pass_cnt++;
    chk_cnt++; if ({bus.flag_c_shad, bus.flag_z_shad} !== 2'b00) $display("FAIL arst_shad got=%b exp=00", {bus.flag_c_shad, bus.flag_z_shad}); else pass_cnt++;
    tick(1);
    reset = 1'b0;
    bus.sei = 1'b1; tick(1); bus.sei = 1'b0;
    tick(LAT);
    chk_cnt++; if ({bus.int_req, bus.pending_q} !== 5'b0_0000) $display("FAIL post_rst got=%b exp=00000", {bus.int_req, bus.pending_q}); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    reset         = 1'b1;
    bus.src_in    = 4'b0000;
    bus.mask_we   = 1'b0;
    bus.mask_din  = 4'b0000;
    bus.sei       = 1'b0;
    bus.cli       = 1'b0;
    bus.int_ack   = 1'b0;
    bus.retie     = 1'b0;
    bus.flag_c_in = 1'b0;
    bus.flag_z_in = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    test_reset();
    test_basic();
    test_ack_retie();
    test_priority();
    test_disabled();
    test_mask();
    test_set_wins();
    test_service_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
